// File: rtl/comp_serie.sv
// Bit-serial N-bit magnitude comparator: folds MSB-first Comp1 triples into a
// registered word-level mayor/igual/menor result with a one-cycle listo pulse.
module comp_serie #(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inicio,
    input  logic bit_valido,
    input  logic mayor_bit,
    input  logic igual_bit,
    input  logic menor_bit,
    output logic ocupado,
    output logic listo,
    output logic mayor,
    output logic igual,
    output logic menor,
    output logic error
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {REPOSO, COMPARA, FIN} estado_t;
    typedef enum logic [1:0] {INDECISO, DEC_MAYOR, DEC_MENOR} decision_t;

    estado_t   estado, estado_sig;
    decision_t dec, dec_sig;
    logic [CW-1:0] cnt, cnt_sig;
    logic ocupado_sig, listo_sig, error_sig;
    logic mayor_sig, igual_sig, menor_sig;
    logic triple_ok;

    assign triple_ok = $onehot({mayor_bit, igual_bit, menor_bit});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        dec_sig    = dec;
        error_sig  = error;
        mayor_sig  = mayor;
        igual_sig  = igual;
        menor_sig  = menor;

        case (estado)
            REPOSO: begin
                cnt_sig = '0;
                dec_sig = INDECISO;
                if (inicio) begin
                    estado_sig = COMPARA;
                    error_sig  = 1'b0;
                end
            end
            COMPARA: begin
                if (inicio) begin
                    // Abort: restart the word, discarding any triple this cycle
                    cnt_sig   = '0;
                    dec_sig   = INDECISO;
                    error_sig = 1'b0;
                end else if (bit_valido) begin
                    cnt_sig = cnt + CW'(1);
                    if (!triple_ok) begin
                        error_sig = 1'b1;
                    end else if (dec == INDECISO) begin
                        if (mayor_bit) begin
                            dec_sig = DEC_MAYOR;
                        end else if (menor_bit) begin
                            dec_sig = DEC_MENOR;
                        end
                    end
                    if (cnt == CW'(N - 1)) begin
                        estado_sig = FIN;
                        mayor_sig  = (dec_sig == DEC_MAYOR);
                        menor_sig  = (dec_sig == DEC_MENOR);
                        igual_sig  = (dec_sig == INDECISO);
                    end
                end
            end
            FIN: begin
                estado_sig = REPOSO;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase

        listo_sig   = (estado_sig == FIN);
        ocupado_sig = (estado_sig != REPOSO);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dec     <= INDECISO;
            ocupado <= 1'b0;
            listo   <= 1'b0;
            mayor   <= 1'b0;
            igual   <= 1'b0;
            menor   <= 1'b0;
            error   <= 1'b0;
        end else begin
            cnt     <= cnt_sig;
            dec     <= dec_sig;
            ocupado <= ocupado_sig;
            listo   <= listo_sig;
            mayor   <= mayor_sig;
            igual   <= igual_sig;
            menor   <= menor_sig;
            error   <= error_sig;
        end
    end

endmodule

// File: tb/tb_comp_serie.sv
// Self-checking bench for comp_serie: directed test-plan scenarios plus
// randomized words checked against a word-level arithmetic reference model.
module tb_comp_serie;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n, inicio, bit_valido, mayor_bit, igual_bit, menor_bit;
    logic ocupado, listo, mayor, igual, menor, error;

    int nvec = 0;
    int nerr = 0;
    logic [2:0] exp_res;
    logic       exp_err;
    logic [5:0] obs;
    logic [2:0] bad_tbl [5];

    assign obs = {ocupado, listo, mayor, igual, menor, error};

    comp_serie #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .bit_valido(bit_valido),
        .mayor_bit(mayor_bit), .igual_bit(igual_bit), .menor_bit(menor_bit),
        .ocupado(ocupado), .listo(listo), .mayor(mayor), .igual(igual),
        .menor(menor), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] comp1(input logic a, input logic b);
        return {a & ~b, a == b, ~a & b};
    endfunction

    // Word-level model: an invalid triple behaves as an equal bit, so mask it out.
    function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input int bad_idx);
        logic [N-1:0] m, am, bm;
        m = '1;
        if (bad_idx >= 0) m[bad_idx] = 1'b0;
        am = a & m;
        bm = b & m;
        if (am > bm) return 3'b100;
        if (am < bm) return 3'b001;
        return 3'b010;
    endfunction

    task automatic set_random_triple;
        {mayor_bit, igual_bit, menor_bit} = 3'($urandom);
    endtask

    task automatic start_word(output int edges);
        inicio = 1'b1;
        bit_valido = 1'($urandom);
        set_random_triple();
        tick();
        inicio = 1'b0;
        exp_err = 1'b0;
        edges = 1;
        nvec++;
        if (obs !== {2'b10, exp_res, exp_err}) begin
            nerr++;
            $display("FAIL start: got %b want %b", obs, {2'b10, exp_res, exp_err});
        end
    endtask

    // gap: 0 none, 1 one idle cycle between valid bits, 2 random 0..2 idle cycles
    task automatic feed_bits(input logic [N-1:0] a, input logic [N-1:0] b, input int gap,
                             input int bad_idx, input logic [2:0] bad_val, inout int edges);
        logic [2:0] nres;
        int g;
        nres = model(a, b, bad_idx);
        for (int i = N - 1; i >= 0; i--) begin
            g = (gap == 1) ? ((i < N - 1) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                bit_valido = 1'b0;
                set_random_triple();
                tick();
                edges++;
                nvec++;
                if (obs !== {2'b10, exp_res, exp_err}) begin
                    nerr++;
                    $display("FAIL gap bit%0d: got %b want %b", i, obs, {2'b10, exp_res, exp_err});
                end
            end
            bit_valido = 1'b1;
            {mayor_bit, igual_bit, menor_bit} = (i == bad_idx) ? bad_val : comp1(a[i], b[i]);
            tick();
            edges++;
            if (i == bad_idx) exp_err = 1'b1;
            if (i > 0) begin
                nvec++;
                if (obs !== {2'b10, exp_res, exp_err}) begin
                    nerr++;
                    $display("FAIL bit%0d: got %b want %b", i, obs, {2'b10, exp_res, exp_err});
                end
            end else begin
                exp_res = nres;
                nvec++;
                if (obs !== {2'b11, exp_res, exp_err}) begin
                    nerr++;
                    $display("FAIL listo a=%h b=%h: got %b want %b", a, b, obs, {2'b11, exp_res, exp_err});
                end
            end
        end
        bit_valido = 1'b0;
    endtask

    // FIN cycle with hostile inputs (all ignored), then optional idle cycles
    task automatic fin_idle(input int nidle);
        inicio = 1'b1;
        bit_valido = 1'b1;
        set_random_triple();
        tick();
        inicio = 1'b0;
        nvec++;
        if (obs !== {2'b00, exp_res, exp_err}) begin
            nerr++;
            $display("FAIL fin: got %b want %b", obs, {2'b00, exp_res, exp_err});
        end
        repeat (nidle) begin
            bit_valido = 1'b1;
            set_random_triple();
            tick();
            nvec++;
            if (obs !== {2'b00, exp_res, exp_err}) begin
                nerr++;
                $display("FAIL idle: got %b want %b", obs, {2'b00, exp_res, exp_err});
            end
        end
        bit_valido = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        inicio = 1'b0;
        bit_valido = 1'b0;
        {mayor_bit, igual_bit, menor_bit} = 3'b000;
        #12;
        nvec++;
        if (obs !== 6'b0) begin
            nerr++;
            $display("FAIL reset: got %b want %b", obs, 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_res = 3'b000;
        exp_err = 1'b0;
        nvec++;
        if (obs !== 6'b0) begin
            nerr++;
            $display("FAIL post_reset: got %b want %b", obs, 6'b0);
        end
    endtask

    task automatic test_mayor;
        int edges;
        start_word(edges);
        feed_bits(8'hA5, 8'hA4, 0, -1, 3'b000, edges);
        nvec++;
        if (edges !== 9) begin
            nerr++;
            $display("FAIL latency_dense: got %0d want %0d", edges, 9);
        end
        fin_idle(2);
    endtask

    task automatic test_gaps;
        int edges;
        start_word(edges);
        feed_bits(8'h3C, 8'h3C, 1, -1, 3'b000, edges);
        nvec++;
        if (edges !== 16) begin
            nerr++;
            $display("FAIL latency_gaps: got %0d want %0d", edges, 16);
        end
        fin_idle(1);
        start_word(edges);
        feed_bits(8'h00, 8'h80, 0, -1, 3'b000, edges);
        fin_idle(1);
    endtask

    task automatic test_abort;
        int edges;
        start_word(edges);
        for (int i = 0; i < 4; i++) begin
            bit_valido = 1'b1;
            {mayor_bit, igual_bit, menor_bit} = (i == 0) ? 3'b100 : (i == 1) ? 3'b111 : 3'b010;
            tick();
            if (i == 1) exp_err = 1'b1;
            nvec++;
            if (obs !== {2'b10, exp_res, exp_err}) begin
                nerr++;
                $display("FAIL abort_pre%0d: got %b want %b", i, obs, {2'b10, exp_res, exp_err});
            end
        end
        inicio = 1'b1;
        bit_valido = 1'b1;
        {mayor_bit, igual_bit, menor_bit} = 3'b100;
        tick();
        inicio = 1'b0;
        exp_err = 1'b0;
        nvec++;
        if (obs !== {2'b10, exp_res, exp_err}) begin
            nerr++;
            $display("FAIL abort: got %b want %b", obs, {2'b10, exp_res, exp_err});
        end
        feed_bits(8'h01, 8'h02, 0, -1, 3'b000, edges);
        fin_idle(2);
    endtask

    task automatic test_invalid;
        int edges;
        start_word(edges);
        feed_bits(8'h5A, 8'h5A, 0, 3, 3'b110, edges);
        fin_idle(3);
        start_word(edges);
        feed_bits(8'h11, 8'h10, 2, -1, 3'b000, edges);
        fin_idle(1);
    endtask

    task automatic test_reset_mid;
        int edges;
        start_word(edges);
        for (int i = 0; i < 5; i++) begin
            bit_valido = 1'b1;
            {mayor_bit, igual_bit, menor_bit} = comp1(1'($urandom), 1'($urandom));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_res = 3'b000;
        exp_err = 1'b0;
        nvec++;
        if (obs !== 6'b0) begin
            nerr++;
            $display("FAIL reset_mid: got %b want %b", obs, 6'b0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bit_valido = 1'b1;
        tick();
        nvec++;
        if (obs !== 6'b0) begin
            nerr++;
            $display("FAIL reset_release: got %b want %b", obs, 6'b0);
        end
        bit_valido = 1'b0;
        start_word(edges);
        feed_bits(8'hC3, 8'hC4, 0, -1, 3'b000, edges);
        fin_idle(0);
    endtask

    task automatic test_back_to_back;
        int edges;
        start_word(edges);
        feed_bits(8'h7F, 8'h80, 0, -1, 3'b000, edges);
        fin_idle(0);
        start_word(edges);
        feed_bits(8'hFE, 8'h01, 2, -1, 3'b000, edges);
        fin_idle(0);
        start_word(edges);
        feed_bits(8'h99, 8'h99, 0, -1, 3'b000, edges);
        fin_idle(0);
    endtask

    task automatic test_random;
        int edges, bidx;
        logic [N-1:0] a, b;
        for (int w = 0; w < 30; w++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : N'($urandom);
            bidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            start_word(edges);
            feed_bits(a, b, 2, bidx, bad_tbl[$urandom_range(0, 4)], edges);
            fin_idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        bad_tbl[0] = 3'b000;
        bad_tbl[1] = 3'b011;
        bad_tbl[2] = 3'b101;
        bad_tbl[3] = 3'b110;
        bad_tbl[4] = 3'b111;
        test_reset();
        test_mayor();
        test_gaps();
        test_abort();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/comp_serie.md
# comp_serie

Bit-serial N-bit magnitude comparator sitting directly downstream of the 1-bit comparator `Comp1`. Each cycle it may accept one `Comp1` result triple (mayor/igual/menor) for one bit pair, most significant bit first. It folds the triples into a registered word-level result and reports it with a one-cycle completion pulse. A word-level comparison therefore costs a single `Comp1` instance plus this block instead of N parallel comparators.

## Interface
Parameters:
- `N`, default 8: word width in bits, i.e. number of bit triples per comparison; legal range 2..32.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `inicio`: input, 1 bit. Start strobe; begins a new comparison.
- `bit_valido`: input, 1 bit. Qualifies the triple on the current cycle.
- `mayor_bit`: input, 1 bit. Bit-level a>b, from `Comp1`.
- `igual_bit`: input, 1 bit. Bit-level a==b, from `Comp1`.
- `menor_bit`: input, 1 bit. Bit-level a<b, from `Comp1`.
- `ocupado`: output, 1 bit. High while a comparison is in progress.
- `listo`: output, 1 bit. One-cycle completion pulse.
- `mayor`: output, 1 bit. Word result A>B, registered and held.
- `igual`: output, 1 bit. Word result A==B, registered and held.
- `menor`: output, 1 bit. Word result A<B, registered and held.
- `error`: output, 1 bit. Sticky flag: a non-one-hot triple was accepted during the current or last word.

## Operation
- States: REPOSO (idle), COMPARA (accepting bits), FIN (publish).
- REPOSO:
  - `inicio`=1 → COMPARA.
  - Bit counter cleared to 0; internal decision cleared to "undecided".
  - `error` cleared.
  - `bit_valido` ignored, including in the cycle `inicio` is sampled.
- COMPARA:
  - A triple is accepted only on a cycle with `bit_valido`=1.
  - Each accepted triple increments the counter (width clog2(N+1)).
  - While undecided:
    - `mayor_bit`=1 → decision A>B.
    - `menor_bit`=1 → decision A<B.
    - `igual_bit`=1 → still undecided.
  - Once decided, later triples are counted but do not change the decision (MSB-first priority).
  - Triple not exactly one-hot (000, 011, 101, 110, 111): sets `error` and is treated as `igual_bit`. It is still counted.
  - On the cycle the Nth triple is accepted → FIN.
  - `bit_valido`=0 cycles are gaps: no count and no state change. There is no timeout.
  - `inicio`=1 in COMPARA aborts the word: counter and decision are cleared, `error` is cleared, and the block stays in COMPARA. A triple presented with `bit_valido` in that same cycle is discarded.
- FIN (exactly one cycle):
  - `listo`=1.
  - `mayor`/`igual`/`menor` loaded from the decision; undecided → `igual`=1.
  - → REPOSO unconditionally. Inputs are ignored in FIN, including `inicio`.
- Result outputs are exactly one-hot after the first completion and hold until the next FIN.
- `ocupado` = 1 in COMPARA and FIN, 0 in REPOSO.

## Timing
- Reset (async assert, any state) → REPOSO. All outputs 0: `ocupado`, `listo`, `mayor`, `igual`, `menor`, `error`. Counter 0. Deassertion is synchronous to `clk`.
- Reset asserted mid-word discards the word with no `listo`. Previous results are also cleared to 0.
- `inicio` sampled at edge k → `ocupado`=1 after edge k. The first triple can be accepted at edge k+1.
- Nth triple accepted at edge m → `listo`=1 and new results visible after edge m. Both `listo` and `ocupado` drop after edge m+1.
- Minimum word time: N+2 cycles from `inicio` to return to REPOSO. Back-to-back `inicio` is accepted on the cycle after FIN.
- `error` updates the cycle after the offending triple. It holds through FIN and REPOSO until the next `inicio`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- N=8; A=0xA5, B=0xA4; triples from a `Comp1` model MSB-first, `bit_valido` held high → `listo` pulse 9 cycles after `inicio`; `mayor`=1, `igual`=0, `menor`=0; `error`=0.
- N=8; A=B=0x3C, with `bit_valido` low on every other cycle → counter advances only on valid cycles; `listo` 16 cycles after `inicio`; `igual`=1. Then A=0x00, B=0x80 → `menor`=1, decided on the first bit and unchanged by the remaining seven.
- Abort: start, feed 4 triples (first one mayor), pulse `inicio`, then feed 8 triples for 0x01 vs 0x02 → exactly one `listo` with `menor`=1.
- Invalid triple 110 at bit 3, all other bits equal → `igual`=1, `error`=1 at `listo`. `error` stays 1 in REPOSO and clears on the cycle after the next `inicio`.
- Reset: assert `rst_n`=0 for 1 cycle after 5 triples → all outputs 0 immediately (async), no `listo`. A subsequent full word completes normally.
- Back-to-back words: `inicio` on the cycle after `listo` → the second word is accepted. Results from the first word hold until the second FIN, then switch to the new one-hot value.
